// File: rtl/keypad_encoder_n.sv
// Debounced priority keypad encoder with a free-running clock divider.
// Optional auto-repeat is built only when the macro KEY_REPEAT_EN is defined.
// Ports:
//   clk       - single clock; all state changes on its rising edge
//   resetn    - asynchronous reset, active low
//   keypad    - raw asynchronous key lines, active high, one per key
//   enablen   - keypad enable, active low
//   code_out  - binary index of the last accepted key
//   loadn     - low while a debounced key is held
//   key_valid - one-cycle pulse per accepted key event
//   pgt_1hz   - registered divided clock (enablen=1) or ~loadn (enablen=0)
module keypad_encoder_n #(
  parameter int NUM_KEYS        = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIV_RATIO       = 100,
  parameter int REPEAT_CYCLES   = 50
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic                enablen,
  output logic [CODE_W-1:0]   code_out,
  output logic                loadn,
  output logic                key_valid,
  output logic                pgt_1hz
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = $clog2(DIV_RATIO);

  if (NUM_KEYS < 2 || NUM_KEYS > 64) begin : g_bad_keys
    $error("NUM_KEYS out of range");
  end
  if (CODE_W < $clog2(NUM_KEYS)) begin : g_bad_code
    $error("CODE_W too narrow");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (DIV_RATIO < 2 || (DIV_RATIO % 2) != 0) begin : g_bad_div
    $error("DIV_RATIO must be even and >= 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rep
    $error("REPEAT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  state_t state, state_n;

  logic [NUM_KEYS-1:0] s1, s2;
  logic [CODE_W-1:0]   pri, cand, cand_n, code_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [DW-1:0]       div;
  logic                div_clk;
  logic                any;
  logic                loadn_n, kv_n;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rep, rep_n;
`endif

  // Highest asserted index wins: later loop iterations override.
  always_comb begin
    pri = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (s2[i]) pri = CODE_W'(i);
    end
  end

  assign any     = |s2;
  assign div_clk = int'(div) < DIV_RATIO / 2;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    code_n  = code_out;
    loadn_n = loadn;
    kv_n    = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_n   = '0;
`endif
    if (enablen) begin
      state_n = S_IDLE;
      loadn_n = 1'b1;
      cnt_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any) begin
            state_n = S_DEBOUNCE;
            cnt_n   = CW'(1);
            cand_n  = pri;
          end
        end
        S_DEBOUNCE: begin
          if (!any) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else if (pri != cand) begin
            cand_n = pri;
            cnt_n  = CW'(1);
          end else if (int'(cnt) + 1 >= DEBOUNCE_CYCLES) begin
            state_n = S_PRESSED;
            code_n  = cand;
            loadn_n = 1'b0;
            kv_n    = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_PRESSED: begin
          if (!any) begin
            state_n = S_RELEASE;
            cnt_n   = CW'(1);
          end else begin
`ifdef KEY_REPEAT_EN
            if (int'(rep) + 1 >= REPEAT_CYCLES) begin
              kv_n  = 1'b1;
              rep_n = '0;
            end else begin
              rep_n = rep + RW'(1);
            end
`endif
          end
        end
        S_RELEASE: begin
          if (any) begin
            state_n = S_PRESSED;
            cnt_n   = '0;
          end else if (int'(cnt) + 1 >= DEBOUNCE_CYCLES) begin
            state_n = S_IDLE;
            loadn_n = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1        <= '0;
      s2        <= '0;
      state     <= S_IDLE;
      cnt       <= '0;
      cand      <= '0;
      code_out  <= '0;
      loadn     <= 1'b1;
      key_valid <= 1'b0;
      div       <= '0;
      pgt_1hz   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep       <= '0;
`endif
    end else begin
      s1        <= keypad;
      s2        <= s1;
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      code_out  <= code_n;
      loadn     <= loadn_n;
      key_valid <= kv_n;
      div       <= (int'(div) == DIV_RATIO - 1) ? '0 : div + DW'(1);
      pgt_1hz   <= enablen ? div_clk : ~loadn;
`ifdef KEY_REPEAT_EN
      rep       <= rep_n;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_encoder_n.sv
// Directed bench for keypad_encoder_n at default parameters.
// Cycle numbers count rising edges after the stimulus change.
module tb_keypad_encoder_n;

  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  keypad;
  logic        enablen;
  logic [3:0]  code_out;
  logic        loadn;
  logic        key_valid;
  logic        pgt_1hz;

  int vecs  = 0;
  int fails = 0;
  int first, pulses, rise;
  logic pg [0:299];

  keypad_encoder_n dut (
    .clk       (clk),
    .resetn    (resetn),
    .keypad    (keypad),
    .enablen   (enablen),
    .code_out  (code_out),
    .loadn     (loadn),
    .key_valid (key_valid),
    .pgt_1hz   (pgt_1hz)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts key_valid pulses over n cycles; first = cycle of the first one.
  task automatic watch(input int n);
    first  = -1;
    pulses = 0;
    for (int c = 1; c <= n; c++) begin
      tick(1);
      if (key_valid) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
  endtask

  initial begin
    resetn  = 1'b0;
    keypad  = '0;
    enablen = 1'b0;
    tick(3);
    check("rst_code", 32'(code_out), 0);
    check("rst_loadn", 32'(loadn), 1);
    check("rst_kv", 32'(key_valid), 0);
    check("rst_pgt", 32'(pgt_1hz), 0);
    resetn = 1'b1;
    tick(3);

    // Single key 5 held 20 cycles.
    keypad = 10'b00_0010_0000;
    first = -1;
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (key_valid) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (c == 6) check("k5_pgt_c6", 32'(pgt_1hz), 0);
      if (c == 7) check("k5_pgt_c7", 32'(pgt_1hz), 1);
    end
    check("k5_first", 32'(first), 6);
    check("k5_pulses", 32'(pulses), 1);
    check("k5_code", 32'(code_out), 5);
    check("k5_loadn", 32'(loadn), 0);
    keypad = '0;
    rise = -1;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      if (loadn && rise < 0) rise = c;
    end
    check("k5_release", 32'(rise), 6);
    check("k5_hold_code", 32'(code_out), 5);

    // Keys 3 and 7 together, then 9 added while pressed.
    keypad = 10'b00_1000_1000;
    watch(12);
    check("k37_first", 32'(first), 6);
    check("k37_code", 32'(code_out), 7);
    keypad = 10'b10_1000_1000;
    watch(12);
    check("k9_pulses", 32'(pulses), 0);
    check("k9_code", 32'(code_out), 7);
    keypad = '0;
    tick(12);
    check("k37_loadn", 32'(loadn), 1);

    // Key 2 bounces for 10 cycles, then stays down from cycle 8.
    first = -1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      keypad = ((c / 2) % 2 == 0 || c >= 8) ? 10'b00_0000_0100 : 10'b0;
      tick(1);
      if (key_valid) begin
        pulses++;
        if (first < 0) first = c + 1;
      end
    end
    check("bnc_first", 32'(first), 14);
    check("bnc_pulses", 32'(pulses), 1);
    check("bnc_code", 32'(code_out), 2);
    keypad = '0;
    tick(12);

    // Disabled: divider on pgt_1hz, presses ignored.
    enablen = 1'b1;
    keypad  = 10'b00_0000_0010;
    pulses  = 0;
    for (int c = 0; c < 300; c++) begin
      tick(1);
      pg[c] = pgt_1hz;
      if (key_valid) pulses++;
    end
    check("dis_pulses", 32'(pulses), 0);
    check("dis_loadn", 32'(loadn), 1);
    check("dis_code", 32'(code_out), 2);
    rise = -1;
    for (int c = 1; c < 150; c++) begin
      if (rise < 0 && !pg[c-1] && pg[c]) rise = c;
    end
    check("div_found", 32'(rise >= 0), 1);
    if (rise >= 0) begin
      check("div_hi_end", 32'(pg[rise+49]), 1);
      check("div_lo_beg", 32'(pg[rise+50]), 0);
      check("div_lo_end", 32'(pg[rise+99]), 0);
      check("div_hi_next", 32'(pg[rise+100]), 1);
    end

    // Enable with key 1 already synchronized: fresh debounce.
    enablen = 1'b0;
    watch(10);
    check("en_first", 32'(first), 4);
    check("en_code", 32'(code_out), 1);

    // Reset while pressed.
    resetn = 1'b0;
    #1;
    check("mid_rst_code", 32'(code_out), 0);
    check("mid_rst_loadn", 32'(loadn), 1);
    check("mid_rst_pgt", 32'(pgt_1hz), 0);
    tick(3);
    resetn = 1'b1;
    watch(10);
    check("post_rst_first", 32'(first), 6);
    check("post_rst_code", 32'(code_out), 1);
    keypad = '0;
    tick(12);

    // Key 4 held 120 cycles.
    keypad = 10'b00_0001_0000;
    watch(120);
    check("k4_first", 32'(first), 6);
    check("k4_code", 32'(code_out), 4);
`ifdef KEY_REPEAT_EN
    check("k4_pulses", 32'(pulses), 3);
`else
    check("k4_pulses", 32'(pulses), 1);
`endif
    keypad = '0;
    tick(12);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/keypad_encoder_n.md
KEYPAD_ENCODER_N -- requirements
Module: keypad_encoder_n

Interface
REQ-001 Parameter NUM_KEYS, default 10: number of keypad lines; legal range 2..64.
REQ-002 Parameter CODE_W, default 4: code output width; SHALL be >= clog2(NUM_KEYS).
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable clk cycles required to accept a press or a release; legal range >= 1.
REQ-004 Parameter DIV_RATIO, default 100: divided-clock period in clk cycles; even and >= 2.
REQ-005 Parameter REPEAT_CYCLES, default 50: auto-repeat interval in clk cycles, used only with KEY_REPEAT_EN.
REQ-006 Port clk, input, 1: single clock; all state on its rising edge.
REQ-007 Port resetn, input, 1: asynchronous active-low reset.
REQ-008 Port keypad, input, NUM_KEYS: raw asynchronous key lines, active-high.
REQ-009 Port enablen, input, 1: active-low keypad enable.
REQ-010 Port code_out, output, CODE_W: binary index of the accepted key.
REQ-011 Port loadn, output, 1: active-low, low while a debounced key is held.
REQ-012 Port key_valid, output, 1: one-cycle pulse per accepted key event.
REQ-013 Port pgt_1hz, output, 1: divided clock or debounced load strobe, selected by enablen.

Function
REQ-014 keypad SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-015 Priority: highest asserted index wins; candidate code = that index, zero-extended to CODE_W.
REQ-016 FSM states IDLE, DEBOUNCE, PRESSED, RELEASE.
REQ-017 IDLE: any key asserted -> DEBOUNCE, counter loaded with 1, candidate latched.
REQ-018 DEBOUNCE: candidate unchanged -> count++; count reaches DEBOUNCE_CYCLES -> PRESSED.
REQ-019 DEBOUNCE: candidate changes -> latch new candidate, counter = 1; all keys released -> IDLE, no pulse.
REQ-020 Entry to PRESSED: code_out <= candidate, loadn <= 0, key_valid high for exactly that one cycle.
REQ-021 PRESSED: code changes while any key remains asserted are ignored; code_out holds.
REQ-022 PRESSED: all keys released -> RELEASE, counter = 1.
REQ-023 RELEASE: release stable DEBOUNCE_CYCLES cycles -> IDLE, loadn <= 1; any key reasserted -> PRESSED, no new pulse, code_out unchanged.
REQ-024 code_out holds the last accepted code in IDLE.
REQ-025 Divider: counter 0..DIV_RATIO-1 wraps to 0; divided clock high for counts 0..DIV_RATIO/2-1, low otherwise; free-running regardless of enablen.
REQ-026 pgt_1hz = ~loadn when enablen = 0; pgt_1hz = divided clock when enablen = 1; registered, 1 cycle after the source.
REQ-027 enablen = 1: FSM forced to IDLE next cycle, loadn = 1, key_valid = 0; an in-progress press is discarded and code_out holds.
REQ-028 enablen falling while a key is held: the press is treated as new (IDLE -> DEBOUNCE).
REQ-029 Latency: stable raw press to key_valid = 2 + DEBOUNCE_CYCLES cycles.

Reset
REQ-030 resetn low: FSM IDLE, code_out 0, loadn 1, key_valid 0, pgt_1hz 0, synchronizer, debounce, divider and repeat counters 0.
REQ-031 Reset mid-press: after release of resetn, a still-held key is debounced as a fresh press.

Configuration
REQ-032 Macro KEY_REPEAT_EN defined: while in PRESSED, key_valid pulses again every REPEAT_CYCLES cycles after the entry pulse; the repeat counter clears on leaving PRESSED.
REQ-033 Macro KEY_REPEAT_EN undefined: exactly one key_valid pulse per PRESSED entry; no repeat counter in the design.

Verification
REQ-034 Defaults; key 5 held 20 cycles -> key_valid pulse at cycle 6, code_out = 5, loadn low until 4 cycles after sync release.
REQ-035 Keys 3 and 7 pressed together -> code_out = 7; key 9 added in PRESSED -> code_out stays 7.
REQ-036 Key 2 bounces 1-0-1 every 2 cycles for 10 cycles, then stable -> no key_valid during the bounce; single pulse 4 cycles after it settles.
REQ-037 enablen = 1 -> pgt_1hz high 50 cycles, low 50 cycles, repeating; key presses produce no key_valid.
REQ-038 resetn asserted in PRESSED -> all outputs reset immediately; a held key produces a fresh pulse 6 cycles after reset release.
REQ-039 KEY_REPEAT_EN, key 4 held 120 cycles -> key_valid at cycles 6, 56 and 106.
